// File: rtl/ifmap_loader_if.sv
// Stream bus feeding the ifmap loader: raster words with valid/ready
// handshake and an end-of-frame marker.
interface ifmap_loader_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;

    // Producer side drives the word stream, loader answers with ready.
    modport master (output in_data, in_valid, in_last, input in_ready);
    modport slave  (input in_data, in_valid, in_last, output in_ready);
endinterface

// File: rtl/ifmap_loader.sv
// ifmap_loader: assembles an optional filter followed by an input image from
// a raster word stream into registered 2-D arrays for the convolution pipe.
// The assembled frame is held with frame_valid until frame_ack.
// Optional feature: define IFMAP_LOADER_CHECKSUM_EN to add the frame_sum
// output, a modulo-2^16 sum of every word accepted in the current frame.
module ifmap_loader #(
    parameter int  IP_DATA_WIDTH = 8,
    parameter int  IFMAP_SIZE    = 5,
    parameter int  FILTER_SIZE   = 3,
    localparam int CNT_WIDTH     = $clog2(IFMAP_SIZE*IFMAP_SIZE+1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic load_filter,
    ifmap_loader_if.slave bus,
    output logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0]   ifmap,
    output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] filter,
    output logic frame_valid,
    input  logic frame_ack,
    output logic frame_err
`ifdef IFMAP_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] frame_sum
`endif
);

    typedef enum logic [1:0] {IDLE, LD_FILT, LD_IMG, HOLD} state_t;

    localparam logic [CNT_WIDTH-1:0] FILT_LAST     = CNT_WIDTH'(FILTER_SIZE*FILTER_SIZE-1);
    localparam logic [CNT_WIDTH-1:0] IMG_LAST      = CNT_WIDTH'(IFMAP_SIZE*IFMAP_SIZE-1);
    localparam logic [CNT_WIDTH-1:0] FILT_COL_LAST = CNT_WIDTH'(FILTER_SIZE-1);
    localparam logic [CNT_WIDTH-1:0] IMG_COL_LAST  = CNT_WIDTH'(IFMAP_SIZE-1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   row_q, row_d;
    logic [CNT_WIDTH-1:0]   col_q, col_d;
    logic                   err_q, err_d;
    logic                   xfer;
    logic                   wrFilt;
    logic                   wrImg;
    logic                   advance;
    logic                   clearCnt;
    logic                   colLast;

    logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0]   ifmap_q;
    logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] filter_q;

`ifdef IFMAP_LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    assign frame_sum = sum_q;
`endif

    assign bus.in_ready = (state_q == LD_FILT) || (state_q == LD_IMG);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign frame_valid  = (state_q == HOLD);
    assign frame_err    = err_q;
    assign ifmap        = ifmap_q;
    assign filter       = filter_q;

    // Next-state logic: walks filter then image words and flags framing errors.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        err_d    = 1'b0;
        wrFilt   = 1'b0;
        wrImg    = 1'b0;
        advance  = 1'b0;
        clearCnt = 1'b0;
        colLast  = (state_q == LD_FILT) ? (col_q == FILT_COL_LAST) : (col_q == IMG_COL_LAST);
`ifdef IFMAP_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = load_filter ? LD_FILT : LD_IMG;
                    clearCnt = 1'b1;
`ifdef IFMAP_LOADER_CHECKSUM_EN
                    sum_d    = '0;
`endif
                end
            end
            LD_FILT: begin
                if (xfer) begin
                    if (bus.in_last) begin
                        err_d    = 1'b1;
                        state_d  = IDLE;
                        clearCnt = 1'b1;
                    end else begin
                        wrFilt = 1'b1;
                        if (cnt_q == FILT_LAST) begin
                            state_d  = LD_IMG;
                            clearCnt = 1'b1;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
            end
            LD_IMG: begin
                if (xfer) begin
                    if (bus.in_last != (cnt_q == IMG_LAST)) begin
                        err_d    = 1'b1;
                        state_d  = IDLE;
                        clearCnt = 1'b1;
                    end else begin
                        wrImg = 1'b1;
                        if (cnt_q == IMG_LAST) begin
                            state_d  = HOLD;
                            clearCnt = 1'b1;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_d = IDLE;
                end
            end
        endcase

        if (clearCnt) begin
            cnt_d = '0;
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (colLast) begin
                col_d = '0;
                row_d = row_q + CNT_WIDTH'(1);
            end else begin
                col_d = col_q + CNT_WIDTH'(1);
            end
        end
`ifdef IFMAP_LOADER_CHECKSUM_EN
        if (wrFilt || wrImg) begin
            sum_d = sum_q + 16'(bus.in_data);
        end
`endif
    end

    // Control registers: state, raster position and the error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
        end
    end

    // Array storage: each element captures the stream word on its own transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifmap_q  <= '0;
            filter_q <= '0;
        end else begin
            for (int r = 0; r < FILTER_SIZE; r++) begin
                for (int c = 0; c < FILTER_SIZE; c++) begin
                    if (wrFilt && row_q == CNT_WIDTH'(r) && col_q == CNT_WIDTH'(c)) begin
                        filter_q[r][c] <= bus.in_data;
                    end
                end
            end
            for (int r = 0; r < IFMAP_SIZE; r++) begin
                for (int c = 0; c < IFMAP_SIZE; c++) begin
                    if (wrImg && row_q == CNT_WIDTH'(r) && col_q == CNT_WIDTH'(c)) begin
                        ifmap_q[r][c] <= bus.in_data;
                    end
                end
            end
        end
    end

`ifdef IFMAP_LOADER_CHECKSUM_EN
    // Running frame checksum, restarted whenever a new frame begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

endmodule

// File: tb/tb_ifmap_loader.sv
// Testbench for ifmap_loader: random and directed frames are driven over the
// stream interface while a reference model predicts each frame outcome into a
// scoreboard queue that an independent monitor drains.
module tb_ifmap_loader;

    localparam int DW  = 8;
    localparam int IS  = 5;
    localparam int FS  = 3;
    localparam int IIW = $clog2(IS);
    localparam int FIW = $clog2(FS);

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic load_filter;
    logic frame_ack;
    logic frame_valid;
    logic frame_err;
    logic [IS-1:0][IS-1:0][DW-1:0] ifmap;
    logic [FS-1:0][FS-1:0][DW-1:0] filter;
`ifdef IFMAP_LOADER_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif

    ifmap_loader_if #(.DATA_WIDTH(DW)) bus ();

    ifmap_loader #(
        .IP_DATA_WIDTH(DW),
        .IFMAP_SIZE(IS),
        .FILTER_SIZE(FS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .load_filter(load_filter),
        .bus(bus),
        .ifmap(ifmap),
        .filter(filter),
        .frame_valid(frame_valid),
        .frame_ack(frame_ack),
        .frame_err(frame_err)
`ifdef IFMAP_LOADER_CHECKSUM_EN
        ,
        .frame_sum(frame_sum)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure frame_valid latency.
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        bit                            isErr;
        logic [IS-1:0][IS-1:0][DW-1:0] ifm;
        logic [FS-1:0][FS-1:0][DW-1:0] flt;
        logic [15:0]                   sum;
        int                            lastEdge;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    exp_t cur;

    logic [IS-1:0][IS-1:0][DW-1:0] modelIfmap;
    logic [FS-1:0][FS-1:0][DW-1:0] modelFilter;
    logic [15:0]                   modelSum;

    int checks = 0;
    int errors = 0;
    bit prevValid = 1'b0;
    bit prevErr = 1'b0;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not matched by model", name);
    endtask

    // Drive one frame. errAt: word index carrying a bad in_last (-1 none);
    // rstAfter: pulse reset after this many image words (-1 none).
    task automatic applyStimulus(input bit loadF, input int pattern, input int errAt,
                                 input int bubblePct, input int rstAfter);
        logic [DW-1:0] words[$];
        int   nF;
        int   total;
        int   guard;
        int   ik;
        bit   acc;
        bit   lastFlag;
        exp_t e;
        nF    = loadF ? FS*FS : 0;
        total = nF + IS*IS;
        for (int k = 0; k < total; k++) begin
            if (pattern == 0)      words.push_back(DW'(k < nF ? k + 1 : k - nF + 1));
            else if (pattern == 1) words.push_back(k < nF ? DW'($urandom) : 8'hFF);
            else                   words.push_back(DW'($urandom));
        end
        start       = 1'b1;
        load_filter = loadF;
        @(posedge clk); #1;
        start       = 1'b0;
        load_filter = 1'b0;
        checkOutput("startAccepted", 256'(bus.in_ready), 256'(1));
        modelSum = '0;
        for (int k = 0; k < total; k++) begin
            lastFlag = (k == total - 1) || (k == errAt);
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                bus.in_valid = ($urandom_range(99) >= 32'(bubblePct));
                bus.in_data  = bus.in_valid ? words[k] : DW'($urandom);
                bus.in_last  = bus.in_valid ? lastFlag : 1'($urandom);
                acc = bus.in_valid && bus.in_ready;
                @(posedge clk); #1;
                guard++;
            end
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            if (!acc) begin
                failNow("readyTimeout");
                return;
            end
            if (k == errAt) begin
                e.isErr    = 1'b1;
                e.ifm      = modelIfmap;
                e.flt      = modelFilter;
                e.sum      = modelSum;
                e.lastEdge = cycle;
                expQ.push_back(e);
                return;
            end
            if (k < nF) begin
                modelFilter[FIW'(k / FS)][FIW'(k % FS)] = words[k];
            end else begin
                ik = k - nF;
                modelIfmap[IIW'(ik / IS)][IIW'(ik % IS)] = words[k];
            end
            modelSum = modelSum + 16'(words[k]);
            if (k >= nF && (k - nF + 1) == rstAfter) begin
                #2 rst = 1'b1;
                #1;
                checkOutput("rstReady", 256'(bus.in_ready), 256'(0));
                checkOutput("rstValid", 256'(frame_valid), 256'(0));
                checkOutput("rstErr", 256'(frame_err), 256'(0));
                checkOutput("rstIfmap", 256'(ifmap), 256'(0));
                checkOutput("rstFilter", 256'(filter), 256'(0));
`ifdef IFMAP_LOADER_CHECKSUM_EN
                checkOutput("rstSum", 256'(frame_sum), 256'(0));
`endif
                @(posedge clk); #1;
                rst         = 1'b0;
                modelIfmap  = '0;
                modelFilter = '0;
                return;
            end
        end
        e.isErr    = 1'b0;
        e.ifm      = modelIfmap;
        e.flt      = modelFilter;
        e.sum      = modelSum;
        e.lastEdge = cycle;
        expQ.push_back(e);
    endtask

    // Wait in HOLD, then acknowledge (optionally with a start that must be ignored).
    task automatic ackFrame(input int holdCycles, input bit withStart);
        repeat (holdCycles) begin
            @(posedge clk); #1;
        end
        frame_ack   = 1'b1;
        start       = withStart;
        load_filter = 1'b1;
        @(posedge clk); #1;
        frame_ack   = 1'b0;
        start       = 1'b0;
        load_filter = 1'b0;
        checkOutput("ackDropsValid", 256'(frame_valid), 256'(0));
        checkOutput("ackIdleNoLoad", 256'(bus.in_ready), 256'(0));
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a frame or an error.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prevValid = 1'b0;
                prevErr   = 1'b0;
            end else begin
                if (prevErr) begin
                    checkOutput("errPulseWidth", 256'(frame_err), 256'(0));
                end else if (frame_err) begin
                    if (expQ.size() == 0) begin
                        failNow("unexpectedErr");
                    end else begin
                        monE = expQ.pop_front();
                        checkOutput("errKind", 256'(frame_err), 256'(monE.isErr));
                        checkOutput("errLatency", 256'(cycle), 256'(monE.lastEdge));
                        checkOutput("validDuringErr", 256'(frame_valid), 256'(0));
                    end
                end
                if (frame_valid && !prevValid) begin
                    if (expQ.size() == 0) begin
                        failNow("unexpectedFrame");
                    end else begin
                        monE = expQ.pop_front();
                        checkOutput("frameKind", 256'(frame_valid), 256'(!monE.isErr));
                        checkOutput("frameLatency", 256'(cycle), 256'(monE.lastEdge));
                        checkOutput("frameIfmap", 256'(ifmap), 256'(monE.ifm));
                        checkOutput("frameFilter", 256'(filter), 256'(monE.flt));
`ifdef IFMAP_LOADER_CHECKSUM_EN
                        checkOutput("frameSum", 256'(frame_sum), 256'(monE.sum));
`endif
                        cur = monE;
                    end
                end
                if (frame_valid) begin
                    checkOutput("holdReady", 256'(bus.in_ready), 256'(0));
                    checkOutput("holdIfmap", 256'(ifmap), 256'(cur.ifm));
                    checkOutput("holdFilter", 256'(filter), 256'(cur.flt));
                end
                prevValid = frame_valid;
                prevErr   = frame_err;
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed and random frame sequence.
    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        load_filter  = 1'b0;
        frame_ack    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        modelIfmap   = '0;
        modelFilter  = '0;
        modelSum     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetReady", 256'(bus.in_ready), 256'(0));
        checkOutput("resetValid", 256'(frame_valid), 256'(0));
        checkOutput("resetErr", 256'(frame_err), 256'(0));
        checkOutput("resetIfmap", 256'(ifmap), 256'(0));
        checkOutput("resetFilter", 256'(filter), 256'(0));
`ifdef IFMAP_LOADER_CHECKSUM_EN
        checkOutput("resetSum", 256'(frame_sum), 256'(0));
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] counting frame with filter");
        applyStimulus(1'b1, 0, -1, 0, -1);
        checkOutput("filter22", 256'(filter[2][2]), 256'(9));
        checkOutput("ifmap44", 256'(ifmap[4][4]), 256'(25));
        checkOutput("ifmap10", 256'(ifmap[1][0]), 256'(6));
`ifdef IFMAP_LOADER_CHECKSUM_EN
        checkOutput("sum370", 256'(frame_sum), 256'(370));
`endif
        ackFrame(2, 1'b0);

        $display("[TB] image-only frame of 0xFF");
        applyStimulus(1'b0, 1, -1, 0, -1);
        ackFrame(1, 1'b0);

        $display("[TB] early in_last framing error");
        applyStimulus(1'b1, 2, FS*FS + 10, 0, -1);
        @(posedge clk); #1;
        checkOutput("errNoValid", 256'(frame_valid), 256'(0));
        checkOutput("errIdle", 256'(bus.in_ready), 256'(0));
        applyStimulus(1'b1, 2, -1, 0, -1);
        ackFrame(0, 1'b0);

        $display("[TB] bubbled frames");
        applyStimulus(1'b1, 0, -1, 50, -1);
        ackFrame(1, 1'b0);
        applyStimulus(1'b0, 2, -1, 50, -1);
        ackFrame(0, 1'b0);

        $display("[TB] reset in mid-frame");
        applyStimulus(1'b1, 2, -1, 0, 12);
        applyStimulus(1'b1, 2, -1, 0, -1);

        $display("[TB] ack with simultaneous start");
        ackFrame(4, 1'b1);
        applyStimulus(1'b0, 2, -1, 0, -1);
        ackFrame(0, 1'b0);

        $display("[TB] random frames");
        repeat (4) begin
            applyStimulus(1'($urandom), 2, -1, 30, -1);
            ackFrame($urandom_range(0, 3), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboardDrained", 256'(expQ.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
